// File: rtl/gpu_pkg.sv
// Shared types for the GPU command dispatcher: controller states and the
// reserved opcode values.
package gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_POP    = 3'd1,
    ST_LATCH  = 3'd2,
    ST_DECODE = 3'd3,
    ST_ISSUE  = 3'd4,
    ST_WAIT   = 3'd5,
    ST_FLUSH  = 3'd6
  } state_e;

  // Reserved opcodes for the default 4-bit opcode; the dispatcher widens them
  // by replicating the bit pattern (all-zeros / all-ones).
  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_FLUSH = 4'hF;

endpackage

// File: rtl/gpu_timeout_counter.sv
// Cycle counter bounding how long the dispatcher waits on a draw unit;
// expired fires during the TIMEOUT_CYCLES-th enabled cycle after a clear.
module gpu_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // counts enabled cycles since the last clear
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= r_count + CNT_W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign expired = enable && (r_count == LAST);

endmodule

// File: rtl/gpu_cmd_dispatcher.sv
// Pops commands from the command FIFO, latches their operands and hands each
// one to a draw unit, a frame flush, or retires it directly (NOP / illegal).
module gpu_cmd_dispatcher
  import gpu_pkg::*;
#(
  parameter int WIDTH_BITS     = 9,
  parameter int HEIGHT_BITS    = 8,
  parameter int CHANNEL_BITS   = 8,
  parameter int OPCODE_BITS    = 4,
  parameter int NUM_UNITS      = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic [OPCODE_BITS-1:0]  opcode_i,
  input  logic [WIDTH_BITS-1:0]   x1_i,
  input  logic [WIDTH_BITS-1:0]   x2_i,
  input  logic [WIDTH_BITS-1:0]   rad_i,
  input  logic [HEIGHT_BITS-1:0]  y1_i,
  input  logic [HEIGHT_BITS-1:0]  y2_i,
  input  logic [2:0]              oct_i,
  input  logic [CHANNEL_BITS-1:0] r_i,
  input  logic [CHANNEL_BITS-1:0] g_i,
  input  logic [CHANNEL_BITS-1:0] b_i,
  input  logic                    fifo_empty_i,
  input  logic [NUM_UNITS-1:0]    finished_i,
  input  logic                    flush_ack_i,
  input  logic                    clear_err_i,
  output logic                    pop_o,
  output logic [WIDTH_BITS-1:0]   x1_o,
  output logic [WIDTH_BITS-1:0]   x2_o,
  output logic [WIDTH_BITS-1:0]   rad_o,
  output logic [HEIGHT_BITS-1:0]  y1_o,
  output logic [HEIGHT_BITS-1:0]  y2_o,
  output logic [2:0]              oct_o,
  output logic [CHANNEL_BITS-1:0] r_o,
  output logic [CHANNEL_BITS-1:0] g_o,
  output logic [CHANNEL_BITS-1:0] b_o,
  output logic [NUM_UNITS-1:0]    run_o,
  output logic                    flush_frame_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_illegal_o,
  output logic                    err_timeout_o
);

  localparam logic [OPCODE_BITS-1:0] L_OP_NOP   = {OPCODE_BITS{OP_NOP[0]}};
  localparam logic [OPCODE_BITS-1:0] L_OP_FLUSH = {OPCODE_BITS{OP_FLUSH[0]}};

  state_e                  r_state, w_next;
  logic [OPCODE_BITS-1:0]  r_opcode;
  logic [WIDTH_BITS-1:0]   r_x1, r_x2, r_rad;
  logic [HEIGHT_BITS-1:0]  r_y1, r_y2;
  logic [2:0]              r_oct;
  logic [CHANNEL_BITS-1:0] r_r, r_g, r_b;
  logic [NUM_UNITS-1:0]    r_sel_oh, w_dec_oh, r_run;
  logic                    r_pop, r_flush, r_busy, r_done, r_err_ill, r_err_to;
  logic                    w_done, w_set_ill, w_set_to, w_cnt_clr, w_cnt_en;
  logic                    w_hit, w_expired;

  gpu_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (w_cnt_clr),
    .enable  (w_cnt_en),
    .expired (w_expired)
  );

  // opcode k in 1..NUM_UNITS selects unit k-1
  always_comb begin
    w_dec_oh = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      w_dec_oh[i] = (r_opcode == OPCODE_BITS'(i + 1));
    end
  end

  assign w_hit = |(finished_i & r_sel_oh);

  // next-state and command-retire decisions
  always_comb begin
    w_next    = r_state;
    w_done    = 1'b0;
    w_set_ill = 1'b0;
    w_set_to  = 1'b0;
    w_cnt_clr = 1'b0;
    w_cnt_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!fifo_empty_i) w_next = ST_POP;
        else               w_next = ST_IDLE;
      end
      ST_POP:   w_next = ST_LATCH;
      ST_LATCH: w_next = ST_DECODE;
      ST_DECODE: begin
        if (r_opcode == L_OP_NOP) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else if (r_opcode == L_OP_FLUSH) begin
          w_next = ST_FLUSH;
        end else if (|w_dec_oh) begin
          w_next = ST_ISSUE;
        end else begin
          w_set_ill = 1'b1;
          w_done    = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_cnt_clr = 1'b1;
        w_next    = ST_WAIT;
      end
      ST_WAIT: begin
        w_cnt_en = 1'b1;
        // a completion in the final cycle beats the timeout
        if (w_hit) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else if (w_expired) begin
          w_set_to = 1'b1;
          w_done   = 1'b1;
          w_next   = ST_IDLE;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_FLUSH: begin
        if (flush_ack_i) begin
          w_done = 1'b1;
          w_next = ST_IDLE;
        end else begin
          w_next = ST_FLUSH;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // state register, registered outputs and sticky error flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= ST_IDLE;
      r_sel_oh  <= '0;
      r_pop     <= 1'b0;
      r_run     <= '0;
      r_flush   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err_ill <= 1'b0;
      r_err_to  <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_sel_oh  <= (r_state == ST_DECODE) ? w_dec_oh : r_sel_oh;
      r_pop     <= (w_next == ST_POP);
      r_run     <= (w_next == ST_ISSUE) ? w_dec_oh : '0;
      r_flush   <= (w_next == ST_FLUSH);
      r_busy    <= (w_next != ST_IDLE);
      r_done    <= w_done;
      r_err_ill <= w_set_ill | (r_err_ill & ~clear_err_i);
      r_err_to  <= w_set_to  | (r_err_to  & ~clear_err_i);
    end
  end

  // command capture: FIFO read data is valid while in LATCH
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_opcode <= '0;
      r_x1 <= '0; r_x2 <= '0; r_rad <= '0;
      r_y1 <= '0; r_y2 <= '0; r_oct <= '0;
      r_r  <= '0; r_g  <= '0; r_b   <= '0;
    end else if (r_state == ST_LATCH) begin
      r_opcode <= opcode_i;
      r_x1 <= x1_i; r_x2 <= x2_i; r_rad <= rad_i;
      r_y1 <= y1_i; r_y2 <= y2_i; r_oct <= oct_i;
      r_r  <= r_i;  r_g  <= g_i;  r_b   <= b_i;
    end else begin
      r_opcode <= r_opcode;
      r_x1 <= r_x1; r_x2 <= r_x2; r_rad <= r_rad;
      r_y1 <= r_y1; r_y2 <= r_y2; r_oct <= r_oct;
      r_r  <= r_r;  r_g  <= r_g;  r_b   <= r_b;
    end
  end

  assign pop_o         = r_pop;
  assign run_o         = r_run;
  assign flush_frame_o = r_flush;
  assign busy_o        = r_busy;
  assign done_o        = r_done;
  assign err_illegal_o = r_err_ill;
  assign err_timeout_o = r_err_to;
  assign x1_o  = r_x1;  assign x2_o = r_x2;  assign rad_o = r_rad;
  assign y1_o  = r_y1;  assign y2_o = r_y2;  assign oct_o = r_oct;
  assign r_o   = r_r;   assign g_o  = r_g;   assign b_o   = r_b;

endmodule

// File: doc/gpu_cmd_dispatcher.md
GPU_CMD_DISPATCHER -- requirements
Module: gpu_cmd_dispatcher

Interface
REQ-001 SHALL have parameters, one per line:
- WIDTH_BITS, default 9, x/radius width.
- HEIGHT_BITS, default 8, y width.
- CHANNEL_BITS, default 8, colour channel width.
- OPCODE_BITS, default 4, opcode width.
- NUM_UNITS, default 4, number of draw units; legal range 1..2^OPCODE_BITS-2.
- TIMEOUT_CYCLES, default 65535, maximum WAIT cycles; minimum 1.
REQ-002 SHALL have ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  reset; one clock, asynchronous, active-low.
- opcode_i  in  OPCODE_BITS  FIFO head opcode.
- x1_i, x2_i, rad_i  in  WIDTH_BITS  FIFO head operands.
- y1_i, y2_i  in  HEIGHT_BITS  FIFO head operands.
- oct_i  in  3  octant.
- r_i, g_i, b_i  in  CHANNEL_BITS  colour.
- fifo_empty_i  in  1  command FIFO empty.
- finished_i  in  NUM_UNITS  per-unit completion pulse.
- flush_ack_i  in  1  frame flush accepted.
- clear_err_i  in  1  clears sticky error flags.
- pop_o  out  1  FIFO read strobe.
- x1_o, x2_o, rad_o, y1_o, y2_o, oct_o, r_o, g_o, b_o  out  matching widths  latched command, shared by all units.
- run_o  out  NUM_UNITS  one-hot start pulse.
- flush_frame_o  out  1  frame flush request.
- busy_o  out  1  state not IDLE.
- done_o  out  1  one-cycle command-retired pulse.
- err_illegal_o  out  1  sticky illegal-opcode flag.
- err_timeout_o  out  1  sticky timeout flag.

Function
REQ-003 SHALL implement states IDLE, POP, LATCH, DECODE, ISSUE, WAIT, FLUSH.
REQ-004 IDLE SHALL go to POP when fifo_empty_i=0 at a clock edge; otherwise it SHALL stay in IDLE.
REQ-005 pop_o SHALL be 1 exactly during POP (one cycle per command); POP SHALL always go to LATCH.
REQ-006 FIFO read data SHALL be valid in the cycle after pop_o; LATCH SHALL register all operands, colour and opcode, then go to DECODE.
REQ-007 DECODE, opcode 0 (NOP): SHALL pulse done_o and go to IDLE.
REQ-008 DECODE, opcode k in 1..NUM_UNITS: SHALL select unit k-1 and go to ISSUE.
REQ-009 DECODE, opcode all-ones (FLUSH): SHALL go to FLUSH.
REQ-010 DECODE, any other opcode: SHALL set err_illegal_o, pulse done_o and go to IDLE.
REQ-011 ISSUE SHALL assert run_o[k-1] for exactly one cycle, clear the timeout counter and go to WAIT; all other run_o bits SHALL stay 0.
REQ-012 WAIT SHALL increment the counter each cycle; finished_i[k-1]=1 SHALL pulse done_o and return to IDLE.
REQ-013 finished_i bits of non-selected units SHALL be ignored in all states.
REQ-014 WAIT counter reaching TIMEOUT_CYCLES SHALL set err_timeout_o, pulse done_o and return to IDLE; finished_i in the same cycle SHALL take priority and no error SHALL be flagged.
REQ-015 FLUSH SHALL hold flush_frame_o=1 until the cycle flush_ack_i=1, then pulse done_o and go to IDLE; flush_ack_i outside FLUSH SHALL be ignored.
REQ-016 Latched outputs SHALL stay constant from LATCH until the next LATCH.
REQ-017 Minimum command latency: fifo_empty_i falling before edge N gives pop_o in cycle N+1 and run_o in cycle N+4.
REQ-018 clear_err_i SHALL clear both sticky flags next edge; an error set in the same cycle SHALL win.
REQ-019 fifo_empty_i changes outside IDLE SHALL be ignored.

Reset
REQ-020 n_rst=0 SHALL immediately force IDLE, counter 0, all outputs 0, including latched operands and error flags.
REQ-021 Reset mid-WAIT or mid-FLUSH SHALL abandon the command without a done_o pulse.

Structure
REQ-022 Package gpu_pkg SHALL hold the state enum and opcode constants OP_NOP=0 and OP_FLUSH=all-ones.
REQ-023 The timeout counter SHALL be sub-module gpu_timeout_counter, with ports clear, enable and expired, parametrised by TIMEOUT_CYCLES.

Verification
REQ-024 Bench SHALL cover:
- Empty FIFO for 5 cycles -> pop_o=0, busy_o=0 throughout.
- Opcode 2, x1=15, y1=150, x2=299, y2=250, RGB=10/9/8; finished_i=4'b0010 after 10 cycles -> run_o=4'b0010 one cycle, operands held, done_o on finish.
- Opcode 1 with finished_i=4'b0100 only, TIMEOUT_CYCLES=8 -> err_timeout_o set after 8 WAIT cycles; clear_err_i clears it.
- Opcode 4'hF; flush_ack_i after 3 cycles -> flush_frame_o high 4 cycles, then IDLE.
- Opcode 4'h9 -> err_illegal_o=1, no run_o, back to IDLE.
- n_rst pulsed low in WAIT -> all outputs 0 at once, no done_o.
